// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the memory-stage controller: state encoding,
// default sizing and the counter width helper.
package mem_stage_ctrl_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int DATA_W_DEF         = 64;
    localparam int PC_W               = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } mem_state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access-cycle counter: synchronous clear has priority over enable, and tc flags
// the last permitted access cycle.
module mem_timeout_cnt
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int                CNT_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: sequences one data-memory access per EX/MEM op, stalls the
// front of the pipeline while it waits, aborts on timeout and redirects taken branches.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int DATA_W         = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exm_MemRead,
    input  logic              exm_MemWrite,
    input  logic              exm_branch,
    input  logic              exm_zero,
    input  logic [DATA_W-1:0] exm_alu_data,
    input  logic [DATA_W-1:0] exm_rd_data,
    input  logic [PC_W-1:0]   exm_branch_target,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              mem_wb_bubble,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              pc_src,
    output logic [PC_W-1:0]   pc_target,
    output logic              flush,
    output logic              timeout_err
);

    mem_state_e        state_q, state_d;
    logic              dmem_req_q, dmem_req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic              mem_op, br_taken;
    logic              cnt_clr, cnt_en, cnt_tc;

    assign mem_op = exm_MemRead | exm_MemWrite;

    mem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        dmem_req_d    = 1'b0;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        cnt_clr       = 1'b1;
        cnt_en        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d    = ST_ACCESS;
                    dmem_req_d = 1'b1;
                    we_d       = exm_MemWrite;
                    addr_d     = exm_alu_data;
                    wdata_d    = exm_rd_data;
                end
            end
            ST_ACCESS: begin
                // Ack is tested before the terminal count so a last-cycle ack still completes.
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        load_data_d  = dmem_rdata;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_tc) begin
                    state_d       = ST_ERR;
                    timeout_err_d = 1'b1;
                end else begin
                    dmem_req_d = 1'b1;
                    cnt_clr    = 1'b0;
                    cnt_en     = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dmem_req_q    <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            load_data_q   <= '0;
            load_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dmem_req_q    <= dmem_req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            load_data_q   <= load_data_d;
            load_valid_q  <= load_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign timeout_err = timeout_err_q;

    // Decode outputs are gated by rst_n so they drop the moment reset asserts.
    assign stall         = rst_n & ((state_q == ST_ACCESS) | ((state_q == ST_IDLE) & mem_op));
    assign mem_wb_bubble = stall | (rst_n & (state_q == ST_ERR));
    assign br_taken      = rst_n & (state_q == ST_IDLE) & exm_branch & exm_zero & ~mem_op;
    assign pc_src        = br_taken;
    assign flush         = br_taken;
    assign pc_target     = br_taken ? exm_branch_target : '0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, reset corner cases
// and random operations checked against a transaction-level expected trace.
module tb_mem_stage_ctrl;

    localparam int TO = 16;
    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          exm_MemRead, exm_MemWrite, exm_branch, exm_zero;
    logic [DW-1:0] exm_alu_data, exm_rd_data;
    logic [7:0]    exm_branch_target;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          stall, mem_wb_bubble;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          pc_src;
    logic [7:0]    pc_target;
    logic          flush;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;

    // Expected architectural state carried between transactions.
    logic [DW-1:0] exp_ld;
    logic          exp_terr;

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .DATA_W        (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exm_MemRead      (exm_MemRead),
        .exm_MemWrite     (exm_MemWrite),
        .exm_branch       (exm_branch),
        .exm_zero         (exm_zero),
        .exm_alu_data     (exm_alu_data),
        .exm_rd_data      (exm_rd_data),
        .exm_branch_target(exm_branch_target),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .stall            (stall),
        .mem_wb_bubble    (mem_wb_bubble),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .flush            (flush),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rd, wr, br, zero;
        logic [DW-1:0] addr, wdata, rdata;
        logic [7:0]    target;
        int            ack_lat;   // ACCESS cycle carrying ack; 0 = never acked
        int            exp_stall;
        int            exp_lv;
        int            exp_pc;
        logic [DW-1:0] exp_ld;
        logic          exp_terr;
    } vec_t;

    function automatic vec_t mk(input logic rd, wr, br, zero, input logic [DW-1:0] addr, wdata,
                                rdata, input logic [7:0] target, input int ack_lat, exp_stall,
                                exp_lv, exp_pc, input logic [DW-1:0] eld, input logic eterr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.br = br; v.zero = zero;
        v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.target = target;
        v.ack_lat = ack_lat; v.exp_stall = exp_stall; v.exp_lv = exp_lv; v.exp_pc = exp_pc;
        v.exp_ld = eld; v.exp_terr = eterr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        exm_MemRead = 1'b0; exm_MemWrite = 1'b0; exm_branch = 1'b0; exm_zero = 1'b0;
        exm_alu_data = '0; exm_rd_data = '0; exm_branch_target = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    // Presents one EX/MEM op (held while stalled) and checks every cycle against the
    // trace implied by the protocol: IDLE, then ACCESS cycles, then DONE or ERR.
    // Called and returns one time unit after a rising edge.
    task automatic do_op(input logic rd, wr, br, zero, input logic [DW-1:0] addr, wdata, rdata,
                         input logic [7:0] target, input int ack_lat, input bit ack_noise,
                         output int stall_cnt, output int lv_cnt, output int pc_cnt);
        logic memop, is_read, taken, done;
        int   n_acc;
        memop   = rd | wr;
        is_read = rd & ~wr;
        taken   = br & zero & ~memop;
        done    = (ack_lat > 0);
        stall_cnt = 0; lv_cnt = 0; pc_cnt = 0;

        exm_MemRead = rd; exm_MemWrite = wr; exm_branch = br; exm_zero = zero;
        exm_alu_data = addr; exm_rd_data = wdata; exm_branch_target = target;
        dmem_ack = ack_noise; dmem_rdata = {$urandom, $urandom};

        @(negedge clk);
        check("idle_stall", stall, memop);
        check("idle_bubble", mem_wb_bubble, memop);
        check("idle_req", dmem_req, 1'b0);
        check("idle_load_valid", load_valid, 1'b0);
        check("idle_pc_src", pc_src, taken);
        check("idle_flush", flush, taken);
        check("idle_pc_target", pc_target, taken ? target : 8'h00);
        check("idle_timeout_err", timeout_err, exp_terr);
        if (stall) stall_cnt++;
        if (pc_src) pc_cnt++;

        if (memop) begin
            n_acc = done ? ack_lat : TO;
            for (int c = 1; c <= n_acc; c++) begin
                @(posedge clk); #1;
                dmem_ack   = (c == ack_lat);
                dmem_rdata = (c == ack_lat) ? rdata : {$urandom, $urandom};
                @(negedge clk);
                check("acc_req", dmem_req, 1'b1);
                check("acc_stall", stall, 1'b1);
                check("acc_bubble", mem_wb_bubble, 1'b1);
                check("acc_we", dmem_we, wr);
                check("acc_addr", dmem_addr, addr);
                check("acc_wdata", dmem_wdata, wdata);
                check("acc_flush", flush, 1'b0);
                check("acc_load_valid", load_valid, 1'b0);
                check("acc_timeout_err", timeout_err, exp_terr);
                if (stall) stall_cnt++;
                if (pc_src) pc_cnt++;
            end
            @(posedge clk); #1;
            dmem_ack   = ack_noise;
            dmem_rdata = {$urandom, $urandom};
            if (done && is_read) exp_ld = rdata;
            if (!done) exp_terr = 1'b1;
            @(negedge clk);
            check("end_stall", stall, 1'b0);
            check("end_req", dmem_req, 1'b0);
            check("end_bubble", mem_wb_bubble, !done);
            check("end_load_valid", load_valid, done && is_read);
            check("end_load_data", load_data, exp_ld);
            check("end_timeout_err", timeout_err, exp_terr);
            check("end_pc_src", pc_src, 1'b0);
            check("end_flush", flush, 1'b0);
            if (load_valid) lv_cnt++;
            if (pc_src) pc_cnt++;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    vec_t tbl [9];

    initial begin
        int sc, lc, pc;
        exp_ld   = '0;
        exp_terr = 1'b0;

        tbl[0] = mk(1, 0, 0, 0, 64'h40,  64'h0,    64'hDEAD, 8'h00, 3,  4,  1, 0, 64'hDEAD, 0);
        tbl[1] = mk(0, 1, 0, 0, 64'h80,  64'h1234, 64'h0,    8'h00, 1,  2,  0, 0, 64'hDEAD, 0);
        tbl[2] = mk(1, 0, 0, 0, 64'h100, 64'h0,    64'hBEEF, 8'h00, TO, 17, 1, 0, 64'hBEEF, 0);
        tbl[3] = mk(1, 1, 0, 0, 64'h88,  64'h5555, 64'h9999, 8'h00, 2,  3,  0, 0, 64'hBEEF, 0);
        tbl[4] = mk(1, 0, 0, 0, 64'h90,  64'h0,    64'h7777, 8'h00, 1,  2,  1, 0, 64'h7777, 0);
        tbl[5] = mk(0, 0, 1, 1, 64'h0,   64'h0,    64'h0,    8'h2C, 0,  0,  0, 1, 64'h7777, 0);
        tbl[6] = mk(0, 0, 1, 0, 64'h0,   64'h0,    64'h0,    8'h2C, 0,  0,  0, 0, 64'h7777, 0);
        tbl[7] = mk(1, 0, 0, 0, 64'h40,  64'h0,    64'h0,    8'h00, 0,  17, 0, 0, 64'h7777, 1);
        tbl[8] = mk(0, 0, 0, 0, 64'h0,   64'h0,    64'h0,    8'h00, 0,  0,  0, 0, 64'h7777, 1);

        // Reset state, with a memory op and a taken branch presented during reset.
        clear_inputs();
        rst_n = 1'b0;
        exm_MemRead = 1'b1; exm_branch = 1'b1; exm_zero = 1'b1; exm_branch_target = 8'hAA;
        #3;
        check("rst_stall", stall, 1'b0);
        check("rst_bubble", mem_wb_bubble, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_addr", dmem_addr, 64'h0);
        check("rst_wdata", dmem_wdata, 64'h0);
        check("rst_load_data", load_data, 64'h0);
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_pc_src", pc_src, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b1;

        // Directed vectors, applied back to back.
        foreach (tbl[i]) begin
            do_op(tbl[i].rd, tbl[i].wr, tbl[i].br, tbl[i].zero, tbl[i].addr, tbl[i].wdata,
                  tbl[i].rdata, tbl[i].target, tbl[i].ack_lat, 1'b0, sc, lc, pc);
            check($sformatf("tbl%0d_stall_cycles", i), sc, tbl[i].exp_stall);
            check($sformatf("tbl%0d_load_valid_pulses", i), lc, tbl[i].exp_lv);
            check($sformatf("tbl%0d_pc_src_pulses", i), pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d_load_data", i), load_data, tbl[i].exp_ld);
            check($sformatf("tbl%0d_timeout_err", i), timeout_err, tbl[i].exp_terr);
        end

        // Reset asserted mid-cycle in the second ACCESS cycle of a load.
        exm_MemRead = 1'b1; exm_alu_data = 64'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        check("pre_rst_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", dmem_req, 1'b0);
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_bubble", mem_wb_bubble, 1'b0);
        check("async_rst_timeout_err", timeout_err, 1'b0);
        check("async_rst_load_data", load_data, 64'h0);
        exp_ld   = '0;
        exp_terr = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'hBAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_load_valid", load_valid, 1'b0);
            check("post_rst_req", dmem_req, 1'b0);
            check("post_rst_stall", stall, 1'b0);
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;

        // Random operation stream against the transaction-level expectations.
        for (int n = 0; n < 60; n++) begin
            int   kind, lat;
            logic rd, wr, br, zr;
            kind = $urandom_range(0, 9);
            rd = 1'b0; wr = 1'b0;
            br = $urandom_range(0, 1) == 1;
            zr = $urandom_range(0, 1) == 1;
            if (kind <= 1) begin
                br = 1'b0;
            end else if (kind <= 3) begin
                br = 1'b1;
            end else if (kind <= 6) begin
                rd = 1'b1;
            end else if (kind <= 8) begin
                wr = 1'b1;
            end else begin
                rd = 1'b1; wr = 1'b1;
            end
            lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
            do_op(rd, wr, br, zr, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 8'($urandom), lat, $urandom_range(0, 1) == 1,
                  sc, lc, pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 16; the maximum number of ACCESS cycles allowed before an access is aborted.
REQ-002 SHALL take parameter DATA_W, default 64; the width of data and address.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 exm_MemRead, exm_MemWrite, exm_branch, exm_zero  input  1 each  control outputs of the EX/MEM register.
REQ-006 exm_alu_data  input  DATA_W  memory address; exm_rd_data  input  DATA_W  store data.
REQ-007 exm_branch_target  input  8  branch PC from EX/MEM.
REQ-008 dmem_ack  input  1  the memory completes the access; dmem_rdata  input  DATA_W  read data, valid with ack.
REQ-009 dmem_req, dmem_we  output  1  memory request and write enable.
REQ-010 dmem_addr, dmem_wdata  output  DATA_W  latched address and store data.
REQ-011 stall  output  1  holds PC, IF/ID, ID/EX and EX/MEM.
REQ-012 mem_wb_bubble  output  1  forces MEM/WB control bits to zero.
REQ-013 load_data  output  DATA_W; load_valid  output  1  read result for MEM/WB.
REQ-014 pc_src  output  1; pc_target  output  8  taken-branch redirect.
REQ-015 flush  output  1  zeroes IF/ID, ID/EX and EX/MEM on the next edge.
REQ-016 timeout_err  output  1  sticky abort flag.

Function
REQ-017 The FSM SHALL have four states: IDLE, ACCESS, DONE and ERR.
REQ-018 In IDLE with exm_MemRead|exm_MemWrite, the FSM SHALL latch addr, wdata and we (=exm_MemWrite), go to ACCESS, and drive stall=1 and mem_wb_bubble=1 that cycle.
REQ-019 In ACCESS, dmem_req=1, stall=1 and mem_wb_bubble=1; addr, wdata and we SHALL stay stable until ack.
REQ-020 In ACCESS with dmem_ack=1, the FSM SHALL capture dmem_rdata into load_data if it is a read and go to DONE; the cycle counter SHALL clear.
REQ-021 In ACCESS without ack, the counter SHALL increment; at count TIMEOUT_CYCLES-1 without ack, the FSM SHALL go to ERR.
REQ-022 An ack arriving on the last permitted cycle SHALL win over the timeout.
REQ-023 In DONE, stall=0 and dmem_req=0, and load_valid=1 for exactly one cycle if the access was a read; the FSM SHALL then return to IDLE.
REQ-024 The EX/MEM register advances at the end of DONE, so back-to-back memory ops each see a full IDLE→ACCESS→DONE sequence, with a minimum of 3 cycles per op.
REQ-025 In ERR, timeout_err SHALL be set (sticky until reset), stall=0, mem_wb_bubble=1 and load_valid=0; the FSM SHALL then return to IDLE.
REQ-026 If exm_MemRead and exm_MemWrite are both 1, the access SHALL be a write and load_valid SHALL stay 0.
REQ-027 In IDLE with exm_branch&exm_zero and no memory op, pc_src=1, flush=1 and pc_target=exm_branch_target SHALL be driven combinationally for that cycle.
REQ-028 pc_src and flush SHALL be 0 in all other states.
REQ-029 A dmem_ack received outside ACCESS SHALL be ignored.
REQ-030 stall and flush SHALL never be 1 in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately force the state to IDLE.
REQ-032 rst_n low SHALL immediately force the counter, dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, load_valid, timeout_err, pc_src, flush, stall and mem_wb_bubble to 0.
REQ-033 Reset during ACCESS SHALL drop dmem_req asynchronously and discard the access; no load_valid SHALL follow.

Structure
REQ-034 The state encoding and the default values of TIMEOUT_CYCLES and DATA_W SHALL live in the shared pipeline package.
REQ-035 The timeout counter SHALL be the single sub-module mem_timeout_cnt, with clear, enable and a terminal-count output.

Verification
REQ-036 Load to 0x40, ack 3 cycles after entering ACCESS with rdata 0xDEAD → stall high 4 cycles, load_data=0xDEAD, one load_valid pulse.
REQ-037 Store of 0x1234 to 0x80, ack in the first ACCESS cycle → dmem_we=1 and dmem_wdata=0x1234 stable, stall high 2 cycles, load_valid=0.
REQ-038 Load with no ack → ERR after 16 ACCESS cycles, timeout_err=1 sticky, mem_wb_bubble=1, stall released.
REQ-039 exm_branch=1, exm_zero=1, target 0x2C → pc_src=1, flush=1, pc_target=0x2C for one cycle, stall=0.
REQ-040 rst_n low in the 2nd ACCESS cycle → dmem_req=0 immediately, state IDLE, no load_valid after release.
REQ-041 MemRead and MemWrite both 1, followed by a back-to-back load → first access is a write, second completes in its own IDLE→ACCESS→DONE.
